// File: rtl/tdm_pkg.sv
// Shared TDM frame-format definitions used by the transmitter and receiver sides.
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } rx_state_e;

    localparam int unsigned TDM_CHANNELS = 4;
    localparam int unsigned ERR_CNT_W    = 8;

endpackage

// File: rtl/tdm_slot_cnt.sv
// Modulo-CHANNELS slot counter with clear, load-to-1 and increment controls.
module tdm_slot_cnt #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load1,
    input  logic             inc,
    output logic [SEL_W-1:0] slot
);

    logic [SEL_W-1:0] slot_d;
    logic [SEL_W-1:0] slot_q;

    // CHANNELS is a power of two, so natural SEL_W-bit wrap gives modulo counting.
    always_comb begin
        slot_d = slot_q;
        if (clr) begin
            slot_d = '0;
        end else if (load1) begin
            slot_d = SEL_W'(1);
        end else if (inc) begin
            slot_d = slot_q + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot = slot_q;

endmodule

// File: rtl/tdm_demux_rx.sv
// Frame-synchronised TDM demultiplexer receiver with lock and sync-error supervision.
// Optional saturating error counter on err_cnt when TDM_RX_ERR_CNT_EN is defined.
module tdm_demux_rx
    import tdm_pkg::*;
#(
    parameter int unsigned CHANNELS = TDM_CHANNELS,
    parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                din,
    input  logic                sync,
    output logic [CHANNELS-1:0] dout,
    output logic                frame_valid,
    output logic [SEL_W-1:0]    slot,
    output logic                locked,
    output logic                sync_err
`ifdef TDM_RX_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(CHANNELS - 1);

    rx_state_e           state_d, state_q;
    logic [CHANNELS-1:0] shadow_d, shadow_q;
    logic [CHANNELS-1:0] dout_d, dout_q;
    logic                frame_valid_d, frame_valid_q;
    logic                sync_err_d, sync_err_q;
    logic                cnt_clr, cnt_load1, cnt_inc;
    logic [SEL_W-1:0]    slot_q;

    tdm_slot_cnt #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_slot_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .load1 (cnt_load1),
        .inc   (cnt_inc),
        .slot  (slot_q)
    );

    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        dout_d        = dout_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        cnt_clr       = 1'b0;
        cnt_load1     = 1'b0;
        cnt_inc       = 1'b0;
        unique case (state_q)
            HUNT: begin
                if (sync) begin
                    shadow_d    = '0;
                    shadow_d[0] = din;
                    cnt_load1   = 1'b1;
                    state_d     = RECV;
                end
            end
            RECV: begin
                if (sync) begin
                    // Early sync restarts the frame here; partial shadow is discarded.
                    sync_err_d  = (slot_q != '0);
                    shadow_d    = '0;
                    shadow_d[0] = din;
                    cnt_load1   = 1'b1;
                end else if (slot_q == '0) begin
                    sync_err_d = 1'b1;
                    cnt_clr    = 1'b1;
                    state_d    = HUNT;
                end else begin
                    shadow_d[slot_q] = din;
                    cnt_inc          = 1'b1;
                    if (slot_q == LAST_SLOT) begin
                        dout_d        = shadow_d;
                        frame_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                cnt_clr = 1'b1;
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            shadow_q      <= '0;
            dout_q        <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            dout_q        <= dout_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

`ifdef TDM_RX_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (sync_err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign dout        = dout_q;
    assign frame_valid = frame_valid_q;
    assign slot        = slot_q;
    assign locked      = (state_q == RECV);
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Directed self-checking bench for tdm_demux_rx (4 channels).
module tb_tdm_demux_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b0;
    logic       sync = 1'b0;
    logic [3:0] dout;
    logic       frame_valid;
    logic [1:0] slot;
    logic       locked;
    logic       sync_err;
`ifdef TDM_RX_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    tdm_demux_rx #(
        .CHANNELS (4),
        .SEL_W    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .sync        (sync),
        .dout        (dout),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err)
`ifdef TDM_RX_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step(input logic s, input logic d);
        sync = s;
        din  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sync  = 1'b0;
        din   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({dout, frame_valid, slot, locked, sync_err} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 000000000", {dout, frame_valid, slot, locked, sync_err});
        end
`ifdef TDM_RX_ERR_CNT_EN
        n_checks++;
        if (err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1);
        n_checks++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL hunt_ignores_din: locked=%b expected 0", locked);
        end
    endtask

    task automatic test_single_frame();
        step(1'b1, 1'b1);
        n_checks++;
        if (locked !== 1'b1 || slot !== 2'd1 || frame_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_on_sync: locked=%b slot=%0d fv=%b expected 1/1/0", locked, slot, frame_valid);
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        n_checks++;
        if (frame_valid !== 1'b0 || dout !== 4'b0000) begin
            n_fail++;
            $display("FAIL no_partial_output: fv=%b dout=%b expected 0/0000", frame_valid, dout);
        end
        step(1'b0, 1'b0);
        n_checks++;
        if (dout !== 4'b0101 || frame_valid !== 1'b1 || sync_err !== 1'b0 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL single_frame: dout=%b fv=%b err=%b locked=%b expected 0101/1/0/1",
                     dout, frame_valid, sync_err, locked);
        end
    endtask

    task automatic test_back_to_back();
        logic seq [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0] exp_dout;
        logic       exp_fv;
        for (int i = 0; i < 8; i++) begin
            step((i % 4) == 0, seq[i]);
            exp_fv   = ((i % 4) == 3);
            exp_dout = (i < 7) ? 4'b0101 : 4'b0011;
            n_checks++;
            if (dout !== exp_dout || frame_valid !== exp_fv || sync_err !== 1'b0) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: dout=%b fv=%b err=%b expected %b/%b/0",
                         i, dout, frame_valid, sync_err, exp_dout, exp_fv);
            end
        end
    endtask

    task automatic test_lost_sync();
        step(1'b0, 1'b1);
        n_checks++;
        if (sync_err !== 1'b1 || locked !== 1'b0 || slot !== 2'd0 || dout !== 4'b0011 || frame_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lost_sync: err=%b locked=%b slot=%0d dout=%b fv=%b expected 1/0/0/0011/0",
                     sync_err, locked, slot, dout, frame_valid);
        end
        step(1'b0, 1'b1);
        n_checks++;
        if (sync_err !== 1'b0 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL lost_sync_pulse: err=%b locked=%b expected 0/0", sync_err, locked);
        end
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        n_checks++;
        if (dout !== 4'b1111 || frame_valid !== 1'b1 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL relock: dout=%b fv=%b locked=%b expected 1111/1/1", dout, frame_valid, locked);
        end
    endtask

    task automatic test_early_sync();
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        n_checks++;
        if (sync_err !== 1'b1 || slot !== 2'd1 || locked !== 1'b1 || frame_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL early_sync: err=%b slot=%0d locked=%b fv=%b expected 1/1/1/0",
                     sync_err, slot, locked, frame_valid);
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        n_checks++;
        if (frame_valid !== 1'b0 || dout !== 4'b1111) begin
            n_fail++;
            $display("FAIL early_sync_no_partial: fv=%b dout=%b expected 0/1111", frame_valid, dout);
        end
        step(1'b0, 1'b1);
        n_checks++;
        if (dout !== 4'b1101 || frame_valid !== 1'b1 || sync_err !== 1'b0) begin
            n_fail++;
            $display("FAIL early_sync_recover: dout=%b fv=%b err=%b expected 1101/1/0", dout, frame_valid, sync_err);
        end
        // sync arriving on the last slot aborts that frame
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        n_checks++;
        if (sync_err !== 1'b1 || frame_valid !== 1'b0 || dout !== 4'b1101 || slot !== 2'd1) begin
            n_fail++;
            $display("FAIL early_sync_last_slot: err=%b fv=%b dout=%b slot=%0d expected 1/0/1101/1",
                     sync_err, frame_valid, dout, slot);
        end
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        n_checks++;
        if (dout !== 4'b1011 || frame_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL last_slot_recover: dout=%b fv=%b expected 1011/1", dout, frame_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({dout, frame_valid, slot, locked, sync_err} !== 9'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected 000000000", {dout, frame_valid, slot, locked, sync_err});
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1);
            n_checks++;
            if (frame_valid !== 1'b0 || locked !== 1'b0 || dout !== 4'b0000) begin
                n_fail++;
                $display("FAIL post_reset_hunt[%0d]: fv=%b locked=%b dout=%b expected 0/0/0000",
                         i, frame_valid, locked, dout);
            end
        end
    endtask

`ifdef TDM_RX_ERR_CNT_EN
    task automatic test_err_cnt();
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
            if (i == 0) begin
                n_checks++;
                if (err_cnt !== 8'd1 || sync_err !== 1'b1) begin
                    n_fail++;
                    $display("FAIL err_cnt_first: cnt=%0d err=%b expected 1/1", err_cnt, sync_err);
                end
            end
        end
        n_checks++;
        if (err_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL err_cnt_saturate: got %0d expected 255", err_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_lost_sync();
        test_early_sync();
        test_reset_mid_frame();
`ifdef TDM_RX_ERR_CNT_EN
        test_err_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tdm_demux_rx.md
# tdm_demux_rx

Frame-synchronised time-division demultiplexer receiver. Sits at the far end of the single-wire link driven by the 4:1 channel mux: it samples one bit per clock off the serial line, tracks slot position from a frame-sync strobe, and presents a complete parallel word of all channels once per frame. It is the receive-side counterpart to the mux/demux pair, replacing the externally driven `sel` with self-generated slot timing and adding lock/error supervision.

## Interface
- `CHANNELS`, default 4: number of TDM slots per frame (one bit per slot); power of two, 2..16.
- `SEL_W`, default 2: slot index width, equal to `$clog2(CHANNELS)`.

Ports:
- `clk` input 1: single clock; all sampling on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `din` input 1: serial TDM data, one slot per clock.
- `sync` input 1: frame strobe, high in the cycle carrying slot 0.
- `dout` output CHANNELS: last complete frame; bit k = slot k.
- `frame_valid` output 1: one-cycle pulse when `dout` updates.
- `slot` output SEL_W: slot index expected on `din` in the current cycle (valid when `locked`).
- `locked` output 1: high while in RECV.
- `sync_err` output 1: one-cycle pulse on any sync violation.
- `err_cnt` output 8: present only with `TDM_RX_ERR_CNT_EN`.

## Operation
- States: HUNT, RECV. Reset state HUNT.
- HUNT: `din` ignored until `sync`=1. Cycle with `sync`=1: `din` captured as slot 0, go RECV, `slot`←1.
- RECV, `slot`=k with 0<k<CHANNELS: capture `din` into shadow bit k, `slot`←k+1 (wraps to 0 after CHANNELS-1).
- Capture of slot CHANNELS-1: shadow plus this bit loaded into `dout` at the same edge; `frame_valid`=1 for the following cycle.
- RECV, `slot`=0 and `sync`=1: normal frame start; capture slot 0, continue. Back-to-back frames need no gap.
- RECV, `slot`=0 and `sync`=0: lost sync. Pulse `sync_err`, go HUNT, `locked`←0. `dout` holds.
- RECV, `slot`≠0 and `sync`=1: early sync. Pulse `sync_err`, discard partial shadow, treat this cycle as slot 0 (capture `din` as bit 0, `slot`←1), stay RECV.
- Partial frames never reach `dout`; `dout` changes only with `frame_valid`.
- `slot` increments modulo CHANNELS; no arithmetic beyond SEL_W bits.

## Timing
- Reset values: `dout`=0, `frame_valid`=0, `slot`=0, `locked`=0, `sync_err`=0, `err_cnt`=0; shadow register cleared.
- Latency: `dout`/`frame_valid` registered, visible the cycle after the last-slot edge, i.e. CHANNELS cycles after the sync cycle's edge.
- All outputs registered; no combinational path from `din`/`sync` to any output.
- `sync_err` is registered: high in the cycle after the violating sample.
- Reset asserted mid-frame: everything returns to reset values immediately; partial frame lost; HUNT after release.
- `frame_valid` and `sync_err` cannot both be high: an early sync on slot CHANNELS-1 aborts the frame (no `frame_valid`).

## Configuration
- `TDM_RX_ERR_CNT_EN` defined: `err_cnt` port present; increments by 1 on each `sync_err`, saturates at 255, cleared only by reset.
- Not defined: port and counter absent; `sync_err` behaviour unchanged.

## Structure
- Shared package `tdm_pkg`: state encoding (HUNT=0, RECV=1), default `CHANNELS`, err-counter width (8), so transmitter and receiver agree on frame format.
- One sub-module: `tdm_slot_cnt`, the modulo-CHANNELS slot counter with load-to-1 and clear inputs; FSM, shadow register and output registers stay in the top.

## Test plan
- Reset then `sync` on first slot, `din` serial 1,0,1,0 → `dout`=4'b0101, `frame_valid` one cycle, 4 cycles after sync edge, `locked`=1.
- Two back-to-back frames 0101 then 1100 (slot0 first) → `dout`=4'b0101 then 4'b0011, two `frame_valid` pulses 4 cycles apart, no `sync_err`.
- After lock, hold `sync`=0 at expected slot 0 → `sync_err` pulse, `locked`=0, `dout` unchanged; next `sync` relocks.
- Assert `sync` at slot 2 mid-frame → `sync_err` pulse, no `frame_valid` for partial frame, new frame completes 4 cycles later with correct bits.
- Pull `rst_n` low at slot 2 → all outputs 0 asynchronously, HUNT after release, no spurious `frame_valid`.
- With `TDM_RX_ERR_CNT_EN`: 300 consecutive lost-sync events → `err_cnt` saturates at 255.
